// File: rtl/pixel_pipe_pkg.sv
// Shared definitions for the pixel pipeline: the dispatcher, its raster
// counter and the result combinator all import this package.
//   PIX_DATA_WIDTH    default coordinate width
//   PIX_SCREEN_WIDTH  default pixels per line
//   PIX_SCREEN_HEIGHT default lines per frame
//   coord_t           coordinate type at the default width
//   dispatch_state_t  dispatcher FSM states
package pixel_pipe_pkg;

    localparam int PIX_DATA_WIDTH    = 32;
    localparam int PIX_SCREEN_WIDTH  = 640;
    localparam int PIX_SCREEN_HEIGHT = 480;

    typedef logic [PIX_DATA_WIDTH-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } dispatch_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y coordinate counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : return to (0,0)
//   advance    : step to the next pixel in raster order
//   x, y       : current pixel coordinate
//   last       : current coordinate is the final pixel of the frame
// Advancing from the last pixel wraps back to (0,0).
module raster_counter
    import pixel_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = PIX_DATA_WIDTH,
    parameter int SCREEN_WIDTH  = PIX_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = PIX_SCREEN_HEIGHT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  last
);

    logic x_end;

    always_comb begin
        x_end = (x == DATA_WIDTH'(SCREEN_WIDTH - 1));
        last  = x_end && (y == DATA_WIDTH'(SCREEN_HEIGHT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last) begin
                x <= '0;
                y <= '0;
            end else if (x_end) begin
                x <= '0;
                y <= y + DATA_WIDTH'(1);
            end else begin
                x <= x + DATA_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_dispatcher.sv
// Hands raster-order pixel jobs to NUM_ENGINES pixel engines in strict
// round-robin, so engine i gets pixels i, i+N, i+2N, ... and the combinator
// can collect results in raster order without reordering.
//   clk, reset   : clock, synchronous active-high reset
//   frame_start  : begin a frame (honoured only in IDLE)
//   taken        : per-engine result consumed by the combinator, engine free
//   start        : per-engine one-cycle job-issue pulse
//   xpixel_o     : per-engine job x coordinate, held until the next issue
//   ypixel_o     : per-engine job y coordinate, held until the next issue
//   busy         : per-engine outstanding-job flag
//   frame_active : high from ISSUE entry until frame_done
//   frame_done   : one-cycle pulse once the last job is taken
//   stall_cycles : (PIXEL_DISPATCH_STALL_CNT_EN only) ISSUE cycles spent
//                  waiting on a busy engine, saturating
// Optional feature macro: PIXEL_DISPATCH_STALL_CNT_EN.
module pixel_dispatcher
    import pixel_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = PIX_DATA_WIDTH,
    parameter int SCREEN_WIDTH  = PIX_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = PIX_SCREEN_HEIGHT,
    parameter int NUM_ENGINES   = 6,
    parameter int ENGINE_BITS   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [NUM_ENGINES-1:0] taken,
    output logic [NUM_ENGINES-1:0] start,
    output logic [DATA_WIDTH-1:0]  xpixel_o [NUM_ENGINES],
    output logic [DATA_WIDTH-1:0]  ypixel_o [NUM_ENGINES],
    output logic [NUM_ENGINES-1:0] busy,
    output logic                   frame_active,
    output logic                   frame_done
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0]  stall_cycles
`endif
);

    dispatch_state_t        state, state_next;
    logic [ENGINE_BITS-1:0] rr_ptr, rr_next;
    logic [NUM_ENGINES-1:0] ptr_onehot, issue_onehot, busy_next;
    logic                   issue, frame_begin, drain_end;
    logic [DATA_WIDTH-1:0]  x, y;
    logic                   last;

    raster_counter #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_raster (
        .clk    (clk),
        .reset  (reset),
        .clear  (frame_begin),
        .advance(issue),
        .x      (x),
        .y      (y),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (frame_start)              state_next = ISSUE;
            ISSUE:   if (issue && last)            state_next = DRAIN;
            DRAIN:   if (busy_next == '0)          state_next = DONE;
            DONE:                                  state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // Issue looks only at the registered busy of the pointed-to engine: a
    // same-cycle taken frees it for the next cycle, and free engines further
    // along the rotation are never used out of turn.
    always_comb begin
        ptr_onehot = '0;
        for (int unsigned i = 0; i < NUM_ENGINES; i++)
            ptr_onehot[i] = (rr_ptr == ENGINE_BITS'(i));
        issue        = (state == ISSUE) && ((busy & ptr_onehot) == '0);
        issue_onehot = issue ? ptr_onehot : '0;
        busy_next    = (busy & ~taken) | issue_onehot;
        rr_next      = (rr_ptr == ENGINE_BITS'(NUM_ENGINES - 1)) ? '0
                                                                  : rr_ptr + ENGINE_BITS'(1);
        frame_begin  = (state == IDLE) && frame_start;
        drain_end    = (state == DRAIN) && (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= '0;
            start        <= '0;
            rr_ptr       <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                xpixel_o[i] <= '0;
                ypixel_o[i] <= '0;
            end
        end else begin
            busy       <= busy_next;
            start      <= issue_onehot;
            frame_done <= drain_end;
            for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
                if (issue_onehot[i]) begin
                    xpixel_o[i] <= x;
                    ypixel_o[i] <= y;
                end
            end
            if (frame_begin)
                rr_ptr <= '0;
            else if (issue)
                rr_ptr <= rr_next;
            if (frame_begin)
                frame_active <= 1'b1;
            else if (drain_end)
                frame_active <= 1'b0;
        end
    end

`ifdef PIXEL_DISPATCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || frame_begin)
            stall_cycles <= '0;
        else if ((state == ISSUE) && !issue && (stall_cycles != '1))
            stall_cycles <= stall_cycles + DATA_WIDTH'(1);
    end
`endif

endmodule
